// File: rtl/i2c_reg_bank_pkg.sv
// Shared constants for the I2C register bank: address map, bit positions, default IDs.
// Latency: n/a (constants only).
// Backpressure: n/a.
package i2c_regbank_pkg;

  localparam logic [7:0] ADDR_ID         = 8'h00;
  localparam logic [7:0] ADDR_VERSION    = 8'h01;
  localparam logic [7:0] ADDR_SCRATCH    = 8'h02;
  localparam logic [7:0] ADDR_CTRL       = 8'h03;
  localparam logic [7:0] ADDR_STATUS     = 8'h04;
  localparam logic [7:0] ADDR_FIFO_DATA  = 8'h05;
  localparam logic [7:0] ADDR_FIFO_LEVEL = 8'h06;
  localparam logic [7:0] ADDR_CNT_LO     = 8'h07;
  localparam logic [7:0] ADDR_CNT_HI     = 8'h08;

  localparam int ST_FIFO_OVF = 0;
  localparam int ST_FIFO_NE  = 1;
  localparam int ST_EVT_SEEN = 2;

  localparam int CTRL_IRQ_EN = 7;

  localparam logic [7:0] DEF_ID_VALUE = 8'hA5;
  localparam logic [7:0] DEF_VERSION  = 8'h01;

endpackage

// File: rtl/i2c_reg_bank_sync_fifo.sv
// Byte mailbox FIFO with fall-through head; rdata reads 0 when empty.
// Latency: push visible at head 1 clk later; pop advances head on the same edge.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign level   = count;
  assign pop_ok  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2c_reg_bank.sv
// I2C slave register bank: IDs, scratch, LED ctrl, W1C status, event counter, mailbox (I2C_REGBANK_FIFO_EN).
// Latency: reg_rdata 1 clk after addr/state change; led_o with its register; irq_o 1 clk later.
// Backpressure: none; every strobe cycle acts, mailbox overflow drops the byte and flags it.
module i2c_reg_bank
  import i2c_regbank_pkg::*;
#(
  parameter logic [7:0] ID_VALUE   = DEF_ID_VALUE,
  parameter logic [7:0] VERSION    = DEF_VERSION,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_wdata,
  input  logic       reg_wr,
  input  logic       reg_rd,
  output logic [7:0] reg_rdata,
  input  logic       evt_i,
  output logic [3:0] led_o,
  output logic       irq_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    scratch;
  logic [3:0]    led;
  logic          irq_en;
  logic          evt_seen;
  logic          fifo_ovf;
  logic [15:0]   cnt;
  logic [7:0]    cnt_hi_shadow;
  logic [2:0]    evt_sync;
  logic          evt_edge;
  logic          wr_status;
  logic          fifo_ovf_set;
  logic          fifo_ne;
  logic [7:0]    fifo_head;
  logic [LW-1:0] fifo_level;
  logic [7:0]    rdata_nxt;

  assign evt_edge  = evt_sync[1] & ~evt_sync[2];
  assign wr_status = reg_wr && (reg_addr == ADDR_STATUS);
  assign led_o     = led;

`ifdef I2C_REGBANK_FIFO_EN
  logic fifo_push;
  logic fifo_pop;
  logic fifo_full;
  logic fifo_empty;

  assign fifo_push    = reg_wr && (reg_addr == ADDR_FIFO_DATA);
  assign fifo_pop     = reg_rd && (reg_addr == ADDR_FIFO_DATA) && !fifo_empty;
  assign fifo_ovf_set = fifo_push && fifo_full && !fifo_pop;
  assign fifo_ne      = !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (reg_wdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );
`else
  assign fifo_ovf_set = 1'b0;
  assign fifo_ne      = 1'b0;
  assign fifo_head    = 8'h00;
  assign fifo_level   = '0;
`endif

  always_comb begin
    rdata_nxt = 8'h00;
    case (reg_addr)
      ADDR_ID:         rdata_nxt = ID_VALUE;
      ADDR_VERSION:    rdata_nxt = VERSION;
      ADDR_SCRATCH:    rdata_nxt = scratch;
      ADDR_CTRL:       rdata_nxt = {irq_en, 3'b000, led};
      ADDR_STATUS:     rdata_nxt = {5'b00000, evt_seen, fifo_ne, fifo_ovf};
      ADDR_FIFO_DATA:  rdata_nxt = fifo_head;
      ADDR_FIFO_LEVEL: rdata_nxt = 8'(fifo_level);
      ADDR_CNT_LO:     rdata_nxt = cnt[7:0];
      ADDR_CNT_HI:     rdata_nxt = cnt_hi_shadow;
      default:         rdata_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch       <= 8'h00;
      led           <= 4'h0;
      irq_en        <= 1'b0;
      evt_seen      <= 1'b0;
      fifo_ovf      <= 1'b0;
      cnt           <= 16'h0000;
      cnt_hi_shadow <= 8'h00;
      evt_sync      <= 3'b000;
      reg_rdata     <= 8'h00;
      irq_o         <= 1'b0;
    end else begin
      evt_sync <= {evt_sync[1:0], evt_i};
      if (reg_wr && (reg_addr == ADDR_SCRATCH)) scratch <= reg_wdata;
      if (reg_wr && (reg_addr == ADDR_CTRL)) begin
        led    <= reg_wdata[3:0];
        irq_en <= reg_wdata[CTRL_IRQ_EN];
      end
      // A new set on the same edge as its W1C wins.
      evt_seen <= evt_edge | (evt_seen & ~(wr_status & reg_wdata[ST_EVT_SEEN]));
      fifo_ovf <= fifo_ovf_set | (fifo_ovf & ~(wr_status & reg_wdata[ST_FIFO_OVF]));
      if (evt_edge) cnt <= cnt + 16'd1;
      if (reg_rd && (reg_addr == ADDR_CNT_LO)) cnt_hi_shadow <= cnt[15:8];
      reg_rdata <= rdata_nxt;
      irq_o     <= irq_en & (fifo_ovf | evt_seen);
    end
  end

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Scoreboard bench for i2c_reg_bank: reads push expected values from a behavioural model,
// a negedge monitor pops and compares whenever reg_rd is presented.
module tb_i2c_reg_bank;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] reg_wdata = 8'h00;
  logic       reg_wr = 1'b0;
  logic       reg_rd = 1'b0;
  logic [7:0] reg_rdata;
  logic       evt_i = 1'b0;
  logic [3:0] led_o;
  logic       irq_o;

  always #5 clk = ~clk;

  i2c_reg_bank #(
    .ID_VALUE   (8'hA5),
    .VERSION    (8'h01),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .evt_i     (evt_i),
    .led_o     (led_o),
    .irq_o     (irq_o)
  );

  // Reference model state
  logic [7:0]  m_scratch;
  logic [7:0]  m_ctrl;
  logic        m_ovf;
  logic        m_evt;
  logic [15:0] m_cnt;
  logic [7:0]  m_shadow;
  logic [7:0]  m_q[$];

  typedef struct {
    logic [7:0] rdata;
    logic [3:0] led;
    logic       irq;
    logic [7:0] addr;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_scratch = 8'h00;
    m_ctrl    = 8'h00;
    m_ovf     = 1'b0;
    m_evt     = 1'b0;
    m_cnt     = 16'h0000;
    m_shadow  = 8'h00;
    m_q.delete();
  endfunction

  function automatic logic m_irq();
    return m_ctrl[7] & (m_ovf | m_evt);
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] a);
    case (a)
      8'h00:   return 8'hA5;
      8'h01:   return 8'h01;
      8'h02:   return m_scratch;
      8'h03:   return m_ctrl;
      8'h04:   return {5'b0, m_evt, (m_q.size() != 0), m_ovf};
      8'h05:   return (m_q.size() != 0) ? m_q[0] : 8'h00;
      8'h06:   return 8'(m_q.size());
      8'h07:   return m_cnt[7:0];
      8'h08:   return m_shadow;
      default: return 8'h00;
    endcase
  endfunction

  // One register access: address settles a cycle, then strobes for one cycle.
  task automatic access(input logic [7:0] a, input logic wr, input logic [7:0] d, input logic rd);
    exp_t e;
    int   pre_size;
    bit   popped;
    @(posedge clk); #1;
    reg_addr  = a;
    reg_wdata = d;
    @(posedge clk); #1;
    if (rd) begin
      e.rdata = m_read(a);
      e.led   = m_ctrl[3:0];
      e.irq   = m_irq();
      e.addr  = a;
      exp_q.push_back(e);
    end
    reg_wr = wr;
    reg_rd = rd;
    @(posedge clk); #1;
    reg_wr = 1'b0;
    reg_rd = 1'b0;
    pre_size = m_q.size();
    popped   = rd && (a == 8'h05) && (pre_size > 0);
    if (popped) void'(m_q.pop_front());
    if (rd && a == 8'h07) m_shadow = m_cnt[15:8];
    if (wr) begin
      case (a)
        8'h02: m_scratch = d;
        8'h03: m_ctrl = d & 8'h8F;
        8'h04: begin
          if (d[0]) m_ovf = 1'b0;
          if (d[2]) m_evt = 1'b0;
        end
`ifdef I2C_REGBANK_FIFO_EN
        8'h05: begin
          if (pre_size < DEPTH || popped) m_q.push_back(d);
          else m_ovf = 1'b1;
        end
`endif
        default: ;
      endcase
      if (a == 8'h03) chk("led_same_cycle", int'(led_o), int'(d[3:0]));
    end
  endtask

  task automatic rd_reg(input logic [7:0] a);
    access(a, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    access(a, 1'b1, d, 1'b0);
  endtask

  task automatic pulse_evt();
    @(posedge clk); #1;
    evt_i = 1'b1;
    repeat (4) @(posedge clk);
    #1 evt_i = 1'b0;
    repeat (4) @(posedge clk);
    m_cnt = m_cnt + 16'd1;
    m_evt = 1'b1;
  endtask

  // W1C of evt_seen lands on the same edge the synchronised rising edge is counted.
  task automatic w1c_with_edge();
    @(posedge clk); #1;
    evt_i     = 1'b1;
    reg_addr  = 8'h04;
    reg_wdata = 8'h04;
    @(posedge clk);
    @(posedge clk); #1;
    reg_wr = 1'b1;
    @(posedge clk); #1;
    reg_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1 evt_i = 1'b0;
    repeat (4) @(posedge clk);
    m_cnt = m_cnt + 16'd1;
    m_evt = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && reg_rd) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: read at addr 0x%0h with no expectation", reg_addr);
      end else begin
        mon_e = exp_q.pop_front();
        chk($sformatf("rdata@%02h", mon_e.addr), int'(reg_rdata), int'(mon_e.rdata));
        chk($sformatf("led@%02h", mon_e.addr), int'(led_o), int'(mon_e.led));
        chk($sformatf("irq@%02h", mon_e.addr), int'(irq_o), int'(mon_e.irq));
      end
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", int'(reg_rdata), 0);
    chk("reset_led", int'(led_o), 0);
    chk("reset_irq", int'(irq_o), 0);
    rst_n = 1'b1;

    for (int a = 0; a < 4; a++) rd_reg(8'(a));

    wr_reg(8'h03, 8'h85);
    rd_reg(8'h03);
    rd_reg(8'h09);

`ifdef I2C_REGBANK_FIFO_EN
    for (int i = 0; i < 8; i++) wr_reg(8'h05, 8'(8'h10 + i));
    wr_reg(8'h05, 8'hAA);
    rd_reg(8'h04);
    rd_reg(8'h06);
    for (int i = 0; i < 9; i++) rd_reg(8'h05);
    rd_reg(8'h06);
    wr_reg(8'h04, 8'h01);
    access(8'h05, 1'b1, 8'h21, 1'b1);
    rd_reg(8'h06);
    for (int i = 0; i < 7; i++) wr_reg(8'h05, 8'(8'h30 + i));
    access(8'h05, 1'b1, 8'hBB, 1'b1);
    rd_reg(8'h06);
    rd_reg(8'h04);
    for (int i = 0; i < 8; i++) rd_reg(8'h05);
`else
    wr_reg(8'h05, 8'h55);
    rd_reg(8'h05);
    rd_reg(8'h06);
    rd_reg(8'h04);
`endif

    repeat (3) pulse_evt();
    rd_reg(8'h04);
    wr_reg(8'h04, 8'h04);
    rd_reg(8'h04);
    w1c_with_edge();
    rd_reg(8'h04);

    while (m_cnt != 16'h01FF) pulse_evt();
    rd_reg(8'h07);
    rd_reg(8'h08);
    pulse_evt();
    rd_reg(8'h08);
    rd_reg(8'h07);

    for (int i = 0; i < 120; i++) begin
      logic [7:0] a;
      logic       wr;
      logic       rd;
      a  = 8'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) a = 8'h05;
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!wr && !rd) rd = 1'b1;
      access(a, wr, 8'($urandom), rd);
    end

    // Reset in the middle of a scratch write: nothing of it survives.
    @(posedge clk); #1;
    reg_addr  = 8'h02;
    reg_wdata = 8'h77;
    reg_wr    = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_rdata", int'(reg_rdata), 0);
    chk("midreset_led", int'(led_o), 0);
    chk("midreset_irq", int'(irq_o), 0);
    @(posedge clk); @(posedge clk); #1;
    reg_wr = 1'b0;
    rst_n  = 1'b1;
    m_reset();
    rd_reg(8'h02);
    rd_reg(8'h07);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
